// File: rtl/my_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : my_ifetch_unit
//  Purpose  : Instruction fetch stage. Reads the byte-wide instruction memory
//             two bytes per instruction, assembles big-endian 16-bit words and
//             presents them to decode through a small queue with a
//             valid/ready handshake and control-flow redirect.
//  Revision : 1.0  initial release
// ============================================================================
module my_ifetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     CK,
  input  logic                     RST,
  output logic [15:0]              MEM_ADDR,
  input  logic [7:0]               MEM_RDATA,
  output logic [15:0]              IR,
  output logic [15:0]              IR_PC,
  output logic                     IR_VALID,
  input  logic                     IR_READY,
  input  logic                     REDIRECT,
  input  logic [15:0]              REDIRECT_PC,
  output logic [$clog2(DEPTH):0]   Q_COUNT
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // HI: fetching the high byte at fpc; LO: fetching the low byte at fpc+1
  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    fpc;
  logic [7:0]     hb;
  logic [15:0]    q_word [DEPTH];
  logic [15:0]    q_pc   [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CW-1:0]  count;

  logic           has_space;
  logic           do_fetch;
  logic           do_push;
  logic           do_pop;

  // Next-state and per-cycle action decode; the LO phase never stalls
  // because room was already reserved when the high byte was taken.
  always_comb begin
    state_nxt = state;
    has_space = (count < FULL);
    do_fetch  = 1'b0;
    do_push   = 1'b0;
    do_pop    = (count != '0) && IR_READY;
    case (state)
      ST_HI: begin
        if (has_space) begin
          do_fetch  = 1'b1;
          state_nxt = ST_LO;
        end
      end
      ST_LO: begin
        do_push   = 1'b1;
        state_nxt = ST_HI;
      end
      default: state_nxt = ST_HI;
    endcase
  end

  // Output drive: memory address follows the fetch phase, head entry is shown
  // only while the queue holds something.
  always_comb begin
    MEM_ADDR = (state == ST_LO) ? (fpc + 16'd1) : fpc;
    IR_VALID = (count != '0);
    IR       = IR_VALID ? q_word[head] : 16'h0000;
    IR_PC    = IR_VALID ? q_pc[head]   : 16'h0000;
    Q_COUNT  = count;
  end

  // FSM state register; reset and redirect both restart at the high byte.
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ST_HI;
    end else if (REDIRECT) begin
      state <= ST_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch address, captured high byte and queue bookkeeping.
  always_ff @(posedge CK) begin
    if (RST) begin
      fpc   <= RESET_PC;
      hb    <= 8'h00;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (REDIRECT) begin
      // A word completing this cycle is dropped along with the queue.
      fpc   <= REDIRECT_PC & 16'hFFFE;
      hb    <= 8'h00;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_fetch) begin
        hb <= MEM_RDATA;
      end
      if (do_push) begin
        fpc  <= fpc + 16'd2;
        tail <= tail + AW'(1);
      end
      if (do_pop) begin
        head <= head + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents need no reset since count gates visibility.
  always_ff @(posedge CK) begin
    if (!RST && !REDIRECT && do_push) begin
      q_word[tail] <= {hb, MEM_RDATA};
      q_pc[tail]   <= fpc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_my_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_my_ifetch_unit
//  Purpose  : Self-checking bench for my_ifetch_unit: directed scenarios with
//             literal expectations plus randomized traffic against a
//             queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_my_ifetch_unit;

  localparam int DEPTH = 2;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        IR_READY = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [15:0] REDIRECT_PC = 16'h0000;
  logic [15:0] MEM_ADDR, IR, IR_PC;
  logic [7:0]  MEM_RDATA;
  logic        IR_VALID;
  logic [1:0]  Q_COUNT;

  // Second instance exercising the address wrap from RESET_PC=FFFE
  logic [15:0] wa, wir, wpc;
  logic [7:0]  wrd;
  logic        wv;
  logic [1:0]  wq;
  logic        w_ready = 1'b1;
  logic        w_redir = 1'b0;
  logic [15:0] w_rpc   = 16'h0000;

  logic [7:0] mem [0:65535];

  always #5 CK = ~CK;

  assign MEM_RDATA = mem[MEM_ADDR];

  function automatic logic [7:0] wrap_mem(input logic [15:0] a);
    case (a)
      16'hFFFE: return 8'hAB;
      16'hFFFF: return 8'hCD;
      16'h0000: return 8'h12;
      16'h0001: return 8'h34;
      default:  return 8'h00;
    endcase
  endfunction
  assign wrd = wrap_mem(wa);

  my_ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .CK(CK), .RST(RST), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .Q_COUNT(Q_COUNT)
  );

  my_ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .CK(CK), .RST(RST), .MEM_ADDR(wa), .MEM_RDATA(wrd),
    .IR(wir), .IR_PC(wpc), .IR_VALID(wv), .IR_READY(w_ready),
    .REDIRECT(w_redir), .REDIRECT_PC(w_rpc), .Q_COUNT(wq)
  );

  // Behavioural model: a queue of fetched words plus the fetch cursor
  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fpc  = 16'h0000;
  logic        m_half = 1'b0;   // high byte already captured
  logic [7:0]  m_hb   = 8'h00;

  ent_t hs_log[$];               // words the DUT handed over
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] ea;
    ea = m_half ? (m_fpc + 16'd1) : m_fpc;
    check("mem_addr", {16'h0, MEM_ADDR}, {16'h0, ea});
    check("ir_valid", {31'h0, IR_VALID}, {31'h0, (mq.size() != 0)});
    check("q_count",  {30'h0, Q_COUNT},  32'(mq.size()));
    check("ir",       {16'h0, IR},    (mq.size() != 0) ? {16'h0, mq[0].word} : 32'h0);
    check("ir_pc",    {16'h0, IR_PC}, (mq.size() != 0) ? {16'h0, mq[0].pc}   : 32'h0);
  endtask

  task automatic model_step(input logic rst, input logic ready, input logic redir,
                            input logic [15:0] rpc);
    int          n;
    logic [15:0] lo_a;
    if (rst) begin
      m_fpc  = 16'h0000;
      m_half = 1'b0;
      mq.delete();
    end else if (redir) begin
      mq.delete();
      m_half = 1'b0;
      m_fpc  = rpc & 16'hFFFE;
    end else begin
      n    = mq.size();
      lo_a = m_fpc + 16'd1;
      if (n > 0 && ready) void'(mq.pop_front());
      if (m_half) begin
        mq.push_back({m_hb, mem[lo_a], m_fpc});
        m_fpc  = m_fpc + 16'd2;
        m_half = 1'b0;
      end else if (n < DEPTH) begin
        m_hb   = mem[m_fpc];
        m_half = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input logic rst, input logic ready, input logic redir,
                       input logic [15:0] rpc);
    if (!rst && ready && IR_VALID === 1'b1) hs_log.push_back({IR, IR_PC});
    RST         = rst;
    IR_READY    = ready;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    model_step(rst, ready, redir, rpc);
    @(negedge CK);
    compare_all();
  endtask

  task automatic check_log(input int idx, input logic [15:0] w, input logic [15:0] pc);
    if (idx >= hs_log.size()) begin
      check("log_len", 32'(hs_log.size()), 32'(idx + 1));
    end else begin
      check("log_word", {16'h0, hs_log[idx].word}, {16'h0, w});
      check("log_pc",   {16'h0, hs_log[idx].pc},   {16'h0, pc});
    end
  endtask

  initial begin
    logic [7:0]  prog [10];
    logic [15:0] exp_w [5];
    int          r;
    logic [15:0] rpc;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    prog  = '{8'h0E, 8'hCB, 8'h09, 8'hEA, 8'h05, 8'h24, 8'h01, 8'hA1, 8'h04, 8'hA4};
    exp_w = '{16'h0ECB, 16'h09EA, 16'h0524, 16'h01A1, 16'h04A4};
    for (int i = 0; i < 10; i++) mem[i] = prog[i];

    // Straight-line fetch with the consumer always ready
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    check("rst_valid", {31'h0, IR_VALID}, 32'h0);
    check("rst_addr",  {16'h0, MEM_ADDR}, 32'h0);
    check("rst_count", {30'h0, Q_COUNT},  32'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("lat1_valid", {31'h0, IR_VALID}, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("lat2_valid", {31'h0, IR_VALID}, 32'h1);
    check("lat2_ir",    {16'h0, IR},       32'h0ECB);
    hs_log.delete();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("seq_len", 32'(hs_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_log(i, exp_w[i], 16'(2 * i));

    // Back-pressure: queue fills and fetch freezes
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("bp_count", {30'h0, Q_COUNT},  32'd2);
    check("bp_addr",  {16'h0, MEM_ADDR}, 32'd4);
    hs_log.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) check_log(i, exp_w[i], 16'(2 * i));

    // Full queue, then pop coinciding with a LO push
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("pp_count", {30'h0, Q_COUNT}, 32'd1);
    check("pp_ir",    {16'h0, IR},      32'h0524);
    check("pp_pc",    {16'h0, IR_PC},   32'h0004);

    // Redirect while one word is queued and the FSM is in LO
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("pre_redir_count", {30'h0, Q_COUNT},  32'd1);
    check("pre_redir_addr",  {16'h0, MEM_ADDR}, 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 16'h0007);
    check("redir_count", {30'h0, Q_COUNT},  32'd0);
    check("redir_addr",  {16'h0, MEM_ADDR}, 32'h0006);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("redir_ir", {16'h0, IR},    32'h01A1);
    check("redir_pc", {16'h0, IR_PC}, 32'h0006);

    // Reset while in LO with one word queued
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("rst_lo_valid", {31'h0, IR_VALID}, 32'h0);
    check("rst_lo_addr",  {16'h0, MEM_ADDR}, 32'h0);
    check("rst_lo_ir",    {16'h0, IR},       32'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("rst_lo_ir2", {16'h0, IR}, 32'h0ECB);

    // Address wrap from FFFE on the second instance
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap_addr0", {16'h0, wa}, 32'hFFFE);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_addr1", {16'h0, wa}, 32'hFFFF);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_ir0",   {16'h0, wir}, 32'hABCD);
    check("wrap_pc0",   {16'h0, wpc}, 32'hFFFE);
    check("wrap_addr2", {16'h0, wa},  32'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_ir1", {16'h0, wir}, 32'h1234);
    check("wrap_pc1", {16'h0, wpc}, 32'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      rpc = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rpc = 16'hFFFC + 16'($urandom_range(0, 3));
      cycle(r < 1, $urandom_range(0, 9) < 7, (r >= 1) && (r < 5), rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/my_ifetch_unit.md
Name: my_ifetch_unit

Overview:
- Instruction fetch stage for the 16-bit CPU. It reads the byte-wide instruction memory two bytes per instruction and assembles big-endian 16-bit instruction words.
- Buffers fetched words in a small queue and presents them to the decode/execute stage (the my_decoder / my_registers / my_ALU path) over a valid/ready handshake.
- Replaces the free-running "PC <= PC+2" fetch. Adds back-pressure and control-flow redirect.

Parameters:
- DEPTH, 2: instruction queue entries; power of two, >= 2.
- RESET_PC, 16'h0000: fetch address loaded on reset; must be even.

Ports:
- CK  input  1  clock; all state changes on posedge CK.
- RST  input  1  reset; synchronous, active-high.
- MEM_ADDR  output  16  byte address to instruction memory.
- MEM_RDATA  input  8  byte at MEM_ADDR; combinational read, valid in the same cycle.
- IR  output  16  instruction word at queue head.
- IR_PC  output  16  byte address of the IR word.
- IR_VALID  output  1  queue non-empty; IR and IR_PC are valid.
- IR_READY  input  1  consumer accepts the head word.
- REDIRECT  input  1  flush the queue and restart fetch at REDIRECT_PC.
- REDIRECT_PC  input  16  new fetch address; bit 0 is ignored (forced to 0).
- Q_COUNT  output  $clog2(DEPTH)+1  number of occupied queue entries.

Behaviour:
- Registered state:
  - FPC: 16-bit next fetch address.
  - FSM state: HI or LO.
  - HB: 8-bit captured high byte.
  - Queue of DEPTH entries, each {word[15:0], pc[15:0]}, with head and tail pointers and a count.
- MEM_ADDR is combinational: FPC in state HI, FPC+1 in state LO (16-bit wrap).
- IR and IR_PC drive the head entry when count>0, and 16'h0000 when empty. IR_VALID = (count!=0). Q_COUNT = count.
- Reset (RST=1 at posedge):
  - FPC=RESET_PC, state=HI, HB=0, count=0, pointers=0.
  - Outputs after reset: IR_VALID=0, IR=0, IR_PC=0, Q_COUNT=0, MEM_ADDR=RESET_PC.
  - RST overrides REDIRECT and all other activity, including mid-instruction (partial HB is discarded).
- FSM in state HI:
  - If count<DEPTH: HB<=MEM_RDATA, go to LO.
  - Else stall in HI; FPC and HB are unchanged.
- FSM in state LO (always completes):
  - Push {HB, MEM_RDATA} with pc=FPC.
  - FPC<=FPC+2; 16'hFFFE wraps to 16'h0000.
  - Go to HI.
  - No overflow is possible: space was checked in HI, and only LO pushes.
- Pop: when IR_VALID & IR_READY at posedge, the head advances and count decrements.
- Simultaneous push and pop: count is unchanged and both take effect.
- REDIRECT=1 at posedge (and RST=0):
  - count=0, pointers=0, partial HB discarded.
  - FPC<=REDIRECT_PC & 16'hFFFE, state<=HI.
  - Priority over push: a word completing in LO that cycle is dropped.
  - A handshake (IR_VALID&IR_READY) in the same cycle counts as a completed transfer for the consumer; the fetch unit simply flushes.
- Latency and throughput:
  - Word at address X enters the queue at the 2nd posedge after fetch of X begins in HI.
  - After reset or redirect, IR_VALID rises after the 2nd posedge.
  - Sustained throughput is 1 word per 2 cycles.
  - With IR_READY held high and the queue never full, IR_VALID pulses one cycle per instruction with count alternating 0/1.
- IR_READY while IR_VALID=0: no effect.
- Back-pressure: IR_READY=0 → queue fills to DEPTH; the FSM then holds in HI with MEM_ADDR=FPC stable until a pop occurs.

Test Plan:
- Memory bytes 0..9 = 0E CB 09 EA 05 24 01 A1 04 A4; RST for 1 cycle, IR_READY=1 → IR sequence 0x0ECB, 0x09EA, 0x0524, 0x01A1, 0x04A4 with IR_PC 0,2,4,6,8; first IR_VALID after the 2nd posedge post-reset; one word every 2 cycles.
- Same memory, IR_READY=0 for 10 cycles → Q_COUNT rises to 2 and holds; MEM_ADDR freezes at 4. Then IR_READY=1 → 0x0ECB, then 0x09EA, then fetch resumes at 4; no word lost or duplicated.
- Queue holding 1 word while the FSM is in LO; assert REDIRECT with REDIRECT_PC=0x0007 → next cycle Q_COUNT=0, MEM_ADDR=0x0006, state HI; next delivered word has IR_PC=0x0006 and IR={mem[6],mem[7]}=0x01A1.
- RESET_PC=16'hFFFE, memory returns 0xAB at 0xFFFE, 0xCD at 0xFFFF, and 0x12 0x34 at 0/1 → IR 0xABCD with IR_PC 0xFFFE, then 0x1234 with IR_PC 0x0000; MEM_ADDR wraps 0xFFFF→0x0000.
- Queue full, then pop and LO push in the same cycle → Q_COUNT unchanged, order preserved.
- RST asserted while in LO with 1 word queued → all outputs return to reset values the next cycle; fetch restarts at RESET_PC.
